// File: rtl/jk_updown_counter.sv
// Modulo-MODULUS up/down counter built from JK toggle stages (J = K = toggle).
// Adds parallel load, count enable, combinational terminal count and a registered wrap pulse.
module jk_updown_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   ModExt = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] jk_next;
  logic [WIDTH-1:0] low_mask;
  logic             at_max, at_zero, load_ok;

  // Bit i toggles when all lower bits are 1 (counting up) or all 0 (counting down).
  always_comb begin
    toggle   = '0;
    low_mask = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      low_mask = '0;
      for (int unsigned j = 0; j < i; j++) begin
        low_mask[j] = 1'b1;
      end
      if (up) begin
        toggle[i] = en & ((q_q & low_mask) == low_mask);
      end else begin
        toggle[i] = en & ((q_q & low_mask) == '0);
      end
    end
  end

  // JK characteristic equation with J = K = toggle.
  always_comb begin
    jk_next = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      jk_next[i] = (toggle[i] & ~q_q[i]) | (~toggle[i] & q_q[i]);
    end
  end

  always_comb begin
    at_max  = (q_q == MaxVal);
    at_zero = (q_q == '0);
    tc      = up ? at_max : at_zero;
    load_ok = ({1'b0, load_val} < ModExt);
  end

  // Load and the wrap boundary override the plain JK next state.
  always_comb begin
    q_d    = jk_next;
    wrap_d = 1'b0;
    if (load) begin
      q_d = load_ok ? load_val : '0;
    end else if (en && tc) begin
      q_d    = up ? '0 : MaxVal;
      wrap_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q    = q_q;
  assign Qn   = ~q_q;
  assign wrap = wrap_q;

  q_in_range_a: assert property (@(posedge clk) disable iff (reset) ({1'b0, q_q} < ModExt));

endmodule
